// File: rtl/hand_card_select.sv
// Card-selection front end for the black-and-white card game: decodes the one-hot
// card switches and holds each player's committed card and per-game used-card mask.

module hcs_player #(
    parameter int NUM_CARDS = 9,
    parameter int CARD_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game_i,
    input  logic                 round_clear_i,
    input  logic                 commit_i,
    input  logic                 sel_valid_i,
    input  logic [NUM_CARDS-1:0] sel_oh_i,
    input  logic [CARD_W-1:0]    sel_idx_i,
    output logic [CARD_W-1:0]    card_o,
    output logic                 ready_o,
    output logic [NUM_CARDS-1:0] used_o,
    output logic                 take_o
);
    logic [CARD_W-1:0]    card_q, card_d;
    logic                 ready_q, ready_d;
    logic [NUM_CARDS-1:0] used_q, used_d;

    // One card per round, each card once per game.
    assign take_o = commit_i & sel_valid_i & ~ready_q & ~(|(used_q & sel_oh_i));

    always_comb begin
        card_d  = card_q;
        ready_d = ready_q;
        used_d  = used_q;
        if (new_game_i) begin
            card_d  = '0;
            ready_d = 1'b0;
            used_d  = '0;
        end else if (round_clear_i) begin
            ready_d = 1'b0;
        end else if (take_o) begin
            card_d  = sel_idx_i;
            ready_d = 1'b1;
            used_d  = used_q | sel_oh_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            card_q  <= '0;
            ready_q <= 1'b0;
            used_q  <= '0;
        end else begin
            card_q  <= card_d;
            ready_q <= ready_d;
            used_q  <= used_d;
        end
    end

    assign card_o  = card_q;
    assign ready_o = ready_q;
    assign used_o  = used_q;
endmodule

module hand_card_select #(
    parameter int NUM_CARDS = 9,
    parameter int SW_W      = 16,
    parameter int CARD_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 round_clear,
    input  logic                 player_sel,
    input  logic                 commit,
    input  logic [SW_W-1:0]      sw,
    output logic [CARD_W-1:0]    p1_card,
    output logic [CARD_W-1:0]    p2_card,
    output logic                 p1_ready,
    output logic                 p2_ready,
    output logic                 both_ready,
    output logic [NUM_CARDS-1:0] p1_used,
    output logic [NUM_CARDS-1:0] p2_used,
    output logic                 accept,
    output logic                 reject
);
    localparam int NUM_PLAYERS = 2;

    logic [NUM_CARDS-1:0]                  sel_oh;
    logic [CARD_W-1:0]                     sel_idx;
    logic                                  sel_valid;
    logic                                  commit_live;
    logic [NUM_PLAYERS-1:0]                pl_commit;
    logic [NUM_PLAYERS-1:0]                pl_take;
    logic [NUM_PLAYERS-1:0]                pl_ready;
    logic [NUM_PLAYERS-1:0][CARD_W-1:0]    pl_card;
    logic [NUM_PLAYERS-1:0][NUM_CARDS-1:0] pl_used;
    logic                                  accept_q, accept_d;
    logic                                  reject_q, reject_d;
    logic                                  unused_sw;

    // Card k sits on sw[SW_W-1-k]; the low switches carry no card.
    assign unused_sw = ^sw[SW_W-NUM_CARDS-1:0];

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NUM_CARDS; k++) begin
            sel_oh[k] = sw[SW_W-1-k];
            if (sw[SW_W-1-k]) sel_idx = CARD_W'(k);
        end
    end

    assign sel_valid   = (sel_oh != '0) && ((sel_oh & (sel_oh - 1'b1)) == '0);
    assign commit_live = commit & ~new_game & ~round_clear;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        assign pl_commit[p] = commit_live & (player_sel == 1'(p));
        hcs_player #(
            .NUM_CARDS (NUM_CARDS),
            .CARD_W    (CARD_W)
        ) u_player (
            .clk           (clk),
            .reset         (reset),
            .new_game_i    (new_game),
            .round_clear_i (round_clear),
            .commit_i      (pl_commit[p]),
            .sel_valid_i   (sel_valid),
            .sel_oh_i      (sel_oh),
            .sel_idx_i     (sel_idx),
            .card_o        (pl_card[p]),
            .ready_o       (pl_ready[p]),
            .used_o        (pl_used[p]),
            .take_o        (pl_take[p])
        );
    end

    // Clears swallow a coincident commit, so neither pulse fires then.
    assign accept_d = commit_live & (|pl_take);
    assign reject_d = commit_live & ~(|pl_take);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            accept_q <= accept_d;
            reject_q <= reject_d;
        end
    end

    assign p1_card    = pl_card[0];
    assign p2_card    = pl_card[1];
    assign p1_ready   = pl_ready[0];
    assign p2_ready   = pl_ready[1];
    assign both_ready = &pl_ready;
    assign p1_used    = pl_used[0];
    assign p2_used    = pl_used[1];
    assign accept     = accept_q;
    assign reject     = reject_q;
endmodule

// File: tb/tb_hand_card_select.sv
// Self-checking bench for hand_card_select: directed game scenarios plus random
// traffic, compared against a rule-level model of both players.

module tb_hand_card_select;
    logic        clk = 1'b0;
    logic        reset, new_game, round_clear, player_sel, commit;
    logic [15:0] sw;
    logic [3:0]  p1_card, p2_card;
    logic        p1_ready, p2_ready, both_ready, accept, reject;
    logic [8:0]  p1_used, p2_used;

    int checks   = 0;
    int failures = 0;

    // Rule-level model: which cards each player has played, current card, ready.
    bit m_used [2][9];
    int m_card [2];
    bit m_ready[2];
    bit m_acc, m_rej;

    hand_card_select dut (
        .clk(clk), .reset(reset), .new_game(new_game), .round_clear(round_clear),
        .player_sel(player_sel), .commit(commit), .sw(sw),
        .p1_card(p1_card), .p2_card(p2_card), .p1_ready(p1_ready), .p2_ready(p2_ready),
        .both_ready(both_ready), .p1_used(p1_used), .p2_used(p2_used),
        .accept(accept), .reject(reject)
    );

    always #5 clk = ~clk;

    function automatic void model_clear_game();
        for (int p = 0; p < 2; p++) begin
            m_card[p]  = 0;
            m_ready[p] = 0;
            for (int k = 0; k < 9; k++) m_used[p][k] = 0;
        end
    endfunction

    function automatic void model_step(bit nc, bit rc, bit ps, bit cm, logic [15:0] s);
        int cnt, idx, t;
        m_acc = 0;
        m_rej = 0;
        if (nc) begin
            model_clear_game();
        end else if (rc) begin
            m_ready[0] = 0;
            m_ready[1] = 0;
        end else if (cm) begin
            cnt = 0;
            idx = 0;
            t   = ps ? 1 : 0;
            for (int k = 0; k < 9; k++)
                if (s[15-k]) begin cnt++; idx = k; end
            if (cnt == 1 && !m_used[t][idx] && !m_ready[t]) begin
                m_card[t]       = idx;
                m_used[t][idx]  = 1;
                m_ready[t]      = 1;
                m_acc           = 1;
            end else begin
                m_rej = 1;
            end
        end
    endfunction

    function automatic logic [30:0] exp_vec();
        logic [8:0] u1, u2;
        for (int k = 0; k < 9; k++) begin
            u1[k] = m_used[0][k];
            u2[k] = m_used[1][k];
        end
        return {4'(m_card[0]), 4'(m_card[1]), m_ready[0], m_ready[1],
                m_ready[0] & m_ready[1], u1, u2, m_acc, m_rej};
    endfunction

    function automatic logic [30:0] act_vec();
        return {p1_card, p2_card, p1_ready, p2_ready, both_ready, p1_used, p2_used,
                accept, reject};
    endfunction

    // Drive one cycle's inputs, step the model at the edge, sample 1 time unit later.
    task automatic do_cycle(input bit nc, input bit rc, input bit ps, input bit cm,
                            input logic [15:0] s);
        new_game = nc; round_clear = rc; player_sel = ps; commit = cm; sw = s;
        @(posedge clk);
        model_step(nc, rc, ps, cm, s);
        #1;
        new_game = 0; round_clear = 0; commit = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        model_clear_game();
        m_acc = 0;
        m_rej = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        new_game = 0; round_clear = 0; player_sel = 0; commit = 0; sw = '0;
        reset = 1;
        #2;
        checks++;
        if (act_vec() !== 31'h0) begin
            failures++;
            $display("FAIL reset_asserted: got %h expected %h", act_vec(), 31'h0);
        end
        apply_reset();
        checks++;
        if (act_vec() !== 31'h0) begin
            failures++;
            $display("FAIL reset_released: got %h expected %h", act_vec(), 31'h0);
        end
    endtask

    task automatic test_basic_round();
        do_cycle(0, 0, 0, 1, 16'h4000);
        checks++;
        if ({p1_card, p1_ready, p1_used, accept, reject} !== {4'd1, 1'b1, 9'b000000010, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL p1_commit: got card=%0d rdy=%b used=%b acc=%b rej=%b expected card=1 rdy=1 used=000000010 acc=1 rej=0",
                     p1_card, p1_ready, p1_used, accept, reject);
        end
        do_cycle(0, 0, 1, 1, 16'h2000);
        checks++;
        if ({p2_card, both_ready, accept} !== {4'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL p2_commit: got card=%0d both=%b acc=%b expected card=2 both=1 acc=1",
                     p2_card, both_ready, accept);
        end
        do_cycle(0, 1, 0, 0, 16'h0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL round_clear: got %h expected %h", act_vec(), exp_vec());
        end
        do_cycle(0, 0, 0, 1, 16'h4000);
        checks++;
        if ({reject, accept, p1_ready, p1_used} !== {1'b1, 1'b0, 1'b0, 9'b000000010}) begin
            failures++;
            $display("FAIL reuse_card: got rej=%b acc=%b rdy=%b used=%b expected rej=1 acc=0 rdy=0 used=000000010",
                     reject, accept, p1_ready, p1_used);
        end
    endtask

    task automatic test_invalid_sel();
        logic [15:0] pats [4];
        pats[0] = 16'h6000; pats[1] = 16'h0040; pats[2] = 16'h0000; pats[3] = 16'hFF80;
        foreach (pats[i]) begin
            do_cycle(0, 0, 1, 1, pats[i]);
            checks++;
            if (act_vec() !== exp_vec() || reject !== 1'b1) begin
                failures++;
                $display("FAIL invalid_sel %h: got %h expected %h", pats[i], act_vec(), exp_vec());
            end
        end
        // Ignored low switches alongside one real card still select that card.
        do_cycle(0, 0, 0, 1, 16'h107F);
        checks++;
        if (act_vec() !== exp_vec() || p1_card !== 4'd3) begin
            failures++;
            $display("FAIL low_bits_ignored: got %h expected %h", act_vec(), exp_vec());
        end
        do_cycle(0, 0, 0, 1, 16'h0800);
        checks++;
        if (act_vec() !== exp_vec() || reject !== 1'b1) begin
            failures++;
            $display("FAIL recommit_ready: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_collision();
        do_cycle(0, 1, 1, 1, 16'h0800);
        checks++;
        if (act_vec() !== exp_vec() || accept !== 1'b0 || reject !== 1'b0) begin
            failures++;
            $display("FAIL rc_with_commit: got %h expected %h", act_vec(), exp_vec());
        end
        do_cycle(1, 1, 1, 1, 16'h0800);
        checks++;
        if (act_vec() !== exp_vec() || {p1_used, p2_used, p1_card, p2_card} !== 26'h0) begin
            failures++;
            $display("FAIL new_game: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_full_mask();
        for (int k = 0; k < 9; k++) begin
            do_cycle(0, 0, 0, 1, 16'h8000 >> k);
            checks++;
            if (act_vec() !== exp_vec() || accept !== 1'b1) begin
                failures++;
                $display("FAIL play_card_%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
            do_cycle(0, 1, 0, 0, 16'h0);
        end
        checks++;
        if (p1_used !== 9'h1FF) begin
            failures++;
            $display("FAIL mask_full: got %h expected 1ff", p1_used);
        end
        do_cycle(0, 0, 0, 1, 16'h0800);
        checks++;
        if (act_vec() !== exp_vec() || reject !== 1'b1) begin
            failures++;
            $display("FAIL tenth_commit: got %h expected %h", act_vec(), exp_vec());
        end
        do_cycle(0, 0, 1, 1, 16'h0800);
        checks++;
        if (act_vec() !== exp_vec() || p2_card !== 4'd4) begin
            failures++;
            $display("FAIL p2_independent: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_held_commit();
        do_cycle(1, 0, 0, 0, 16'h0);
        do_cycle(0, 0, 0, 1, 16'h0100);
        do_cycle(0, 0, 0, 1, 16'h0100);
        checks++;
        if (act_vec() !== exp_vec() || reject !== 1'b1 || p1_card !== 4'd7) begin
            failures++;
            $display("FAIL held_commit: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        bit nc, rc, ps, cm;
        for (int n = 0; n < 400; n++) begin
            nc = ($urandom_range(0, 39) == 0);
            rc = ($urandom_range(0, 5) == 0);
            ps = 1'($urandom_range(0, 1));
            cm = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) s = 16'($urandom);
            else s = (16'h8000 >> $urandom_range(0, 8)) | 16'($urandom_range(0, 127));
            do_cycle(nc, rc, ps, cm, s);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h", n, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midround();
        do_cycle(1, 0, 0, 0, 16'h0);
        do_cycle(0, 0, 0, 1, 16'h2000);
        do_cycle(0, 0, 1, 1, 16'h0080);
        #2;
        reset = 1;
        model_clear_game();
        m_acc = 0;
        m_rej = 0;
        #1;
        checks++;
        if (act_vec() !== 31'h0) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), 31'h0);
        end
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        do_cycle(0, 0, 0, 1, 16'h2000);
        checks++;
        if (act_vec() !== exp_vec() || accept !== 1'b1) begin
            failures++;
            $display("FAIL commit_after_reset: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic_round();
        test_invalid_sel();
        test_clear_collision();
        test_full_mask();
        test_held_commit();
        test_random();
        test_reset_midround();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
